// File: rtl/led_matrix_scroller.sv
// Glyph-code FIFO and column scroller feeding an 8x8 LED matrix driver.
// Presents the current/next codes to external decoders and merges their bitmaps into a sliding window.
module led_matrix_scroller #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned STEP_DIV = 1024,
    parameter logic [7:0]  BLANK    = 8'hFF
) (
    input  logic        stateClk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        empty,
    output logic        busy,
    output logic [7:0]  cur_code,
    output logic [7:0]  nxt_code,
    input  logic [63:0] cur_array,
    input  logic [63:0] nxt_array,
    output logic [63:0] array_out
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SCROLL = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [7:0]         r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_full;
    logic               r_empty;
    logic [7:0]         r_cur_code;
    logic [7:0]         r_nxt_code;
    logic [2:0]         r_offset;
    logic [DIV_W-1:0]   r_div;

    logic               w_tick;
    logic               w_boundary;
    logic               w_start;
    logic               w_done;
    logic               w_push;
    logic               w_pop;
    logic               w_has_data;
    logic [7:0]         w_head;
    logic [CNT_W-1:0]   w_count_nxt;

    // Control strobes; clr suppresses every FIFO side effect in its cycle
    assign w_has_data  = (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_tick      = (r_state == S_SCROLL) && en && (r_div == DIV_LAST);
    assign w_boundary  = w_tick && (r_offset == 3'd7);
    assign w_start     = (r_state == S_IDLE) && en && w_has_data;
    assign w_done      = w_boundary && (r_nxt_code == BLANK) && !w_has_data;
    assign w_pop       = !clr && (w_start || (w_boundary && w_has_data));
    assign w_push      = !clr && wr_en && !r_full;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // State register
    always_ff @(posedge stateClk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        if (clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_start) w_state_nxt = S_SCROLL;
                S_SCROLL: if (w_done)  w_state_nxt = S_IDLE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs: each row is the 16-pixel strip {next, cur} viewed through an 8-wide window at offset
    always_comb begin
        busy      = (r_state == S_SCROLL);
        array_out = '0;
        if (r_state == S_SCROLL) begin
            for (int r = 0; r < 8; r++) begin
                array_out[r*8 +: 8] = 8'({nxt_array[r*8 +: 8], cur_array[r*8 +: 8]} >> r_offset);
            end
        end
    end

    // FIFO storage
    always_ff @(posedge stateClk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // FIFO bookkeeping, glyph codes, column offset and step divider
    always_ff @(posedge stateClk or posedge rst) begin
        if (rst) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_cur_code <= BLANK;
            r_nxt_code <= BLANK;
            r_offset   <= '0;
            r_div      <= '0;
        end else if (clr) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_cur_code <= BLANK;
            r_nxt_code <= BLANK;
            r_offset   <= '0;
            r_div      <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_FULL);
            r_empty <= (w_count_nxt == '0);

            if (w_start) begin
                r_cur_code <= BLANK;
                r_nxt_code <= w_head;
                r_offset   <= '0;
                r_div      <= '0;
            end else if ((r_state == S_SCROLL) && en) begin
                r_div <= w_tick ? '0 : r_div + DIV_W'(1);
                if (w_tick) begin
                    if (r_offset != 3'd7) begin
                        r_offset <= r_offset + 3'd1;
                    end else begin
                        r_offset <= '0;
                        if (w_done) begin
                            r_cur_code <= BLANK;
                            r_nxt_code <= BLANK;
                        end else begin
                            r_cur_code <= r_nxt_code;
                            r_nxt_code <= w_has_data ? w_head : BLANK;
                        end
                    end
                end
            end
        end
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign cur_code = r_cur_code;
    assign nxt_code = r_nxt_code;

endmodule
